// File: rtl/ex05_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex05_pkg
// Purpose  : Shared constants, types and command decoding for the vending
//            machine credit accumulator.
// Contents : WIDTH, MAX_AMOUNT  - credit width and saturation ceiling (NIS)
//            amount_t           - credit/coin value type
//            cmd_e              - prioritised command seen on a clock edge
//            decode_cmd()       - collapses clear/load/add into one command
// Revision : 1.0 - initial release
// ============================================================================
package ex05_pkg;

    localparam int WIDTH      = 5;
    localparam int MAX_AMOUNT = 31;

    typedef logic [WIDTH-1:0] amount_t;

    typedef enum logic [1:0] {
        CMD_HOLD  = 2'd0,
        CMD_ADD   = 2'd1,
        CMD_LOAD  = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_e;

    // Several command inputs may be high together; the strongest one wins:
    // clear over load over add. Nothing asserted means hold.
    function automatic cmd_e decode_cmd(input logic i_clear,
                                        input logic i_load,
                                        input logic i_add);
        cmd_e v_cmd;
        if (i_clear) begin
            v_cmd = CMD_CLEAR;
        end else if (i_load) begin
            v_cmd = CMD_LOAD;
        end else if (i_add) begin
            v_cmd = CMD_ADD;
        end else begin
            v_cmd = CMD_HOLD;
        end
        return v_cmd;
    endfunction

endpackage : ex05_pkg
`default_nettype wire

// File: rtl/ex05_sat_add.sv
`default_nettype none
// ============================================================================
// Module   : ex05_sat_add
// Purpose  : Combinational saturating adder for credit values.
// Ports    : a, b  (in)  - unsigned operands
//            sum   (out) - a + b, clamped to MAX_AMOUNT
//            ovf   (out) - high when the true a + b exceeds MAX_AMOUNT
// Revision : 1.0 - initial release
// ============================================================================
module ex05_sat_add #(
    parameter int WIDTH      = ex05_pkg::WIDTH,
    parameter int MAX_AMOUNT = ex05_pkg::MAX_AMOUNT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    import ex05_pkg::*;

    localparam logic [WIDTH:0]   c_max_ext = (WIDTH+1)'(MAX_AMOUNT);
    localparam logic [WIDTH-1:0] c_max     = WIDTH'(MAX_AMOUNT);

    // One extra bit of headroom so the true sum never wraps before the
    // comparison against the ceiling.
    logic [WIDTH:0] w_sum_ext;

    assign w_sum_ext = {1'b0, a} + {1'b0, b};
    assign ovf       = (w_sum_ext > c_max_ext);
    assign sum       = ovf ? c_max : w_sum_ext[WIDTH-1:0];

endmodule : ex05_sat_add
`default_nettype wire

// File: rtl/ex05_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : ex05_accumulator
// Purpose  : Vending machine credit register. Holds 0..MAX_AMOUNT NIS and can
//            be cleared, loaded or accumulated with saturation. A sticky
//            overflow flag records any attempt to exceed the ceiling.
// Ports    : clk            (in)  - system clock, rising edge
//            rst            (in)  - asynchronous active-high reset
//            clear          (in)  - zero credit and overflow
//            load           (in)  - credit <= amount (clamped)
//            add            (in)  - credit <= credit + amount (saturating)
//            amount         (in)  - coin/credit value, unsigned NIS
//            stored_amount  (out) - registered credit
//            overflow       (out) - registered sticky overflow flag
// Revision : 1.0 - initial release
// ============================================================================
module ex05_accumulator #(
    parameter int WIDTH      = ex05_pkg::WIDTH,
    parameter int MAX_AMOUNT = ex05_pkg::MAX_AMOUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             add,
    input  logic [WIDTH-1:0] amount,
    output logic [WIDTH-1:0] stored_amount,
    output logic             overflow
);

    import ex05_pkg::*;

    localparam logic [WIDTH-1:0] c_zero = '0;

    logic [WIDTH-1:0] r_stored;
    logic             r_overflow;

    cmd_e             w_cmd;
    logic [WIDTH-1:0] w_add_sum;
    logic             w_add_ovf;
    logic [WIDTH-1:0] w_load_sum;
    logic             w_load_ovf;
    logic [WIDTH-1:0] w_stored_nxt;
    logic             w_overflow_nxt;

    assign w_cmd = decode_cmd(clear, load, add);

    // Accumulate path: current credit plus incoming amount.
    ex05_sat_add #(
        .WIDTH      (WIDTH),
        .MAX_AMOUNT (MAX_AMOUNT)
    ) u_add_path (
        .a   (r_stored),
        .b   (amount),
        .sum (w_add_sum),
        .ovf (w_add_ovf)
    );

    // Load path: adding to zero reuses the same clamp, so a load above the
    // ceiling saturates and raises overflow exactly like an add would.
    ex05_sat_add #(
        .WIDTH      (WIDTH),
        .MAX_AMOUNT (MAX_AMOUNT)
    ) u_load_clamp (
        .a   (c_zero),
        .b   (amount),
        .sum (w_load_sum),
        .ovf (w_load_ovf)
    );

    always_comb begin
        w_stored_nxt   = r_stored;
        w_overflow_nxt = r_overflow;
        case (w_cmd)
            CMD_CLEAR: begin
                w_stored_nxt   = '0;
                w_overflow_nxt = 1'b0;
            end
            CMD_LOAD: begin
                // A load restarts the flag: it reflects only this load.
                w_stored_nxt   = w_load_sum;
                w_overflow_nxt = w_load_ovf;
            end
            CMD_ADD: begin
                // Adds can only set the flag, never clear it.
                w_stored_nxt   = w_add_sum;
                w_overflow_nxt = r_overflow | w_add_ovf;
            end
            default: begin
                w_stored_nxt   = r_stored;
                w_overflow_nxt = r_overflow;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stored   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_stored   <= w_stored_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    assign stored_amount = r_stored;
    assign overflow      = r_overflow;

endmodule : ex05_accumulator
`default_nettype wire

// File: tb/tb_ex05_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex05_accumulator
// Purpose  : Self-checking bench for ex05_accumulator. Stimulus drives
//            commands on the falling edge and queues the credit a plain
//            integer model predicts; a monitor compares after each rising
//            edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex05_accumulator;

    localparam int W    = 5;
    localparam int MAXA = 31;

    logic         clk    = 1'b0;
    logic         rst    = 1'b0;
    logic         clear  = 1'b0;
    logic         load   = 1'b0;
    logic         add    = 1'b0;
    logic [W-1:0] amount = '0;
    logic [W-1:0] stored_amount;
    logic         overflow;

    always #5 clk = ~clk;

    ex05_accumulator #(
        .WIDTH      (W),
        .MAX_AMOUNT (MAXA)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .load          (load),
        .add           (add),
        .amount        (amount),
        .stored_amount (stored_amount),
        .overflow      (overflow)
    );

    typedef struct {
        logic [W-1:0] credit;
        logic         ovf;
        string        tag;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    // Reference model: credit as a plain integer plus a sticky flag.
    int m_credit = 0;
    bit m_ovf    = 1'b0;

    task automatic check(input string tag, input logic [W-1:0] act_c,
                         input logic act_o, input logic [W-1:0] exp_c,
                         input logic exp_o);
        checks++;
        if (act_c !== exp_c || act_o !== exp_o) begin
            errors++;
            $display("FAIL %s: got stored_amount=%0d overflow=%0b, expected stored_amount=%0d overflow=%0b",
                     tag, act_c, act_o, exp_c, exp_o);
        end
    endtask

    // Drive one command for the coming rising edge and queue the outcome.
    task automatic issue(input bit c, input bit l, input bit a,
                         input int amt, input string tag);
        exp_t e;
        @(negedge clk);
        clear  = c;
        load   = l;
        add    = a;
        amount = W'(amt);
        if (c) begin
            m_credit = 0;
            m_ovf    = 1'b0;
        end else if (l) begin
            if (amt > MAXA) begin
                m_credit = MAXA;
                m_ovf    = 1'b1;
            end else begin
                m_credit = amt;
                m_ovf    = 1'b0;
            end
        end else if (a) begin
            if (m_credit + amt > MAXA) begin
                m_credit = MAXA;
                m_ovf    = 1'b1;
            end else begin
                m_credit = m_credit + amt;
            end
        end
        e.credit = m_credit[W-1:0];
        e.ovf    = m_ovf;
        e.tag    = tag;
        sb.push_back(e);
    endtask

    task automatic quiesce();
        @(negedge clk);
        clear = 1'b0;
        load  = 1'b0;
        add   = 1'b0;
    endtask

    always begin : monitor
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, stored_amount, overflow, e.credit, e.ovf);
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got time=%0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int r;
        int amt;

        // Reset asserted before any clock edge must clear outputs at once.
        #1 rst = 1'b1;
        #2;
        check("reset_async_initial", stored_amount, overflow, '0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", stored_amount, overflow, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Load sweep.
        issue(0, 1, 0, 0,  "load_0");
        issue(0, 1, 0, 15, "load_15");
        issue(0, 1, 0, 31, "load_31_max");
        issue(0, 1, 0, 10, "load_10");
        issue(0, 1, 0, 20, "load_20");
        issue(0, 1, 0, 25, "load_25");

        // Accumulate up to the exact ceiling.
        issue(0, 1, 0, 10, "acc_load_10");
        issue(0, 0, 1, 15, "acc_add_15");
        issue(0, 0, 1, 6,  "acc_add_6_exact_max");

        // Saturation and sticky flag.
        issue(0, 1, 0, 25, "sat_load_25");
        issue(0, 0, 1, 20, "sat_add_20");
        issue(0, 0, 1, 0,  "sat_add_0_sticky");
        issue(0, 0, 1, 3,  "sat_add_at_max");
        issue(0, 1, 0, 5,  "sat_load_5_clears");
        issue(0, 0, 1, 0,  "add_0_unchanged");
        issue(0, 1, 0, 31, "load_31_again");
        issue(0, 0, 1, 1,  "add_1_at_max");
        issue(0, 0, 0, 9,  "hold_after_ovf");
        issue(1, 0, 0, 9,  "clear_drops_ovf");

        // Priority.
        issue(0, 1, 0, 12, "prio_load_12");
        issue(1, 1, 1, 7,  "prio_clear_wins");
        issue(0, 1, 0, 3,  "prio_load_3");
        issue(0, 1, 1, 9,  "prio_load_over_add");

        // Hold with a wandering amount and a mid-cycle command glitch.
        for (int i = 0; i < 5; i++) begin
            issue(0, 0, 0, int'($urandom_range(0, MAXA)), "hold_random");
            #2 load = 1'b1;
            #1 amount = W'($urandom_range(0, MAXA));
            #1 load = 1'b0;
        end

        // Asynchronous reset in the middle of a cycle with overflow set.
        issue(0, 1, 0, 31, "pre_rst_load");
        issue(0, 0, 1, 5,  "pre_rst_ovf");
        quiesce();
        #2 rst = 1'b1;
        #1;
        check("reset_async_midcycle", stored_amount, overflow, '0, 1'b0);
        m_credit = 0;
        m_ovf    = 1'b0;
        load     = 1'b1;
        amount   = W'(20);
        @(posedge clk);
        #1;
        check("reset_overrides_load", stored_amount, overflow, '0, 1'b0);
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        issue(0, 0, 1, 4, "first_edge_after_rst");

        // Randomised command mix.
        for (int i = 0; i < 300; i++) begin
            r   = int'($urandom_range(0, 99));
            amt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, MAXA));
            if (r < 4) begin
                issue(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, amt, "rand_clear");
            end else if (r < 22) begin
                issue(0, 1, $urandom_range(0, 1) == 1, amt, "rand_load");
            end else if (r < 85) begin
                issue(0, 0, 1, amt, "rand_add");
            end else begin
                issue(0, 0, 0, amt, "rand_hold");
            end
        end
        quiesce();

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ex05_accumulator
`default_nettype wire
